// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU control codes,
// controller state encoding and the multicycle counter width.
package alu_share_arbiter_pkg;

    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_SRAI    = 3'b001,
        ALU_SUB     = 3'b010,
        ALU_MUL     = 3'b011,
        ALU_XOR     = 3'b100,
        ALU_AND     = 3'b101,
        ALU_ILLEGAL = 3'b110,
        ALU_SLL     = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Wide enough for MUL_CYCLES-1 up to 14.
    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way grant: a lone valid requester wins; on a tie the requester that was
// not served last wins, or requester 0 when fixed priority is selected.
module alu_share_arbiter_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        if (valid == 2'b11) begin
            grant_id = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
        if (valid != 2'b00) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Schedules two requesters onto one external combinational ALU: accepts one op,
// drives the ALU from latched operands (held longer for MUL), returns the result.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic [WIDTH-1:0] req0_data2_i,
    input  logic [2:0]       req0_ctrl_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_data1_i,
    input  logic [WIDTH-1:0] req1_data2_i,
    input  logic [2:0]       req1_ctrl_i,
    output logic             resp0_valid_o,
    input  logic             resp0_ready_i,
    output logic             resp1_valid_o,
    input  logic             resp1_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_zero_o,
    output logic             resp_err_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    state_e             state, next_state;
    logic               last_grant;
    logic               id;
    logic [WIDTH-1:0]   op1, op2;
    logic [2:0]         op_ctrl;
    logic [CNT_W-1:0]   cnt;

    logic [1:0]         grant;
    logic               grant_id;
    logic               accept;
    logic               resp_hs;
    logic               alu_drive;
    logic [2:0]         sel_ctrl;

    alu_share_arbiter_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .valid      ({req1_valid_i, req0_valid_i}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign accept    = (state == S_IDLE) && (grant != 2'b00);
    assign sel_ctrl  = grant_id ? req1_ctrl_i : req0_ctrl_i;
    assign resp_hs   = (state == S_RESP) && (id ? resp1_ready_i : resp0_ready_i);
    assign alu_drive = (state == S_EXEC) || (state == S_MUL);

    assign req0_ready_o  = (state == S_IDLE) && grant[0];
    assign req1_ready_o  = (state == S_IDLE) && grant[1];
    assign resp0_valid_o = (state == S_RESP) && !id;
    assign resp1_valid_o = (state == S_RESP) && id;
    assign busy_o        = (state != S_IDLE);

    // The ALU only ever sees latched operands, never the illegal code.
    assign alu_data1_o = alu_drive ? op1     : '0;
    assign alu_data2_o = alu_drive ? op2     : '0;
    assign alu_ctrl_o  = alu_drive ? op_ctrl : 3'b000;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) begin
                if (sel_ctrl == ALU_MUL)          next_state = S_MUL;
                else if (sel_ctrl == ALU_ILLEGAL) next_state = S_RESP;
                else                              next_state = S_EXEC;
            end
            S_EXEC: next_state = S_RESP;
            S_MUL:  if (cnt == '0) next_state = S_RESP;
            S_RESP: if (resp_hs) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant  <= 1'b1;
            id          <= 1'b0;
            op1         <= '0;
            op2         <= '0;
            op_ctrl     <= 3'b000;
            cnt         <= '0;
            resp_data_o <= '0;
            resp_zero_o <= 1'b0;
            resp_err_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    id      <= grant_id;
                    op1     <= grant_id ? req1_data1_i : req0_data1_i;
                    op2     <= grant_id ? req1_data2_i : req0_data2_i;
                    op_ctrl <= sel_ctrl;
                    cnt     <= CNT_W'(MUL_CYCLES - 1);
                    if (sel_ctrl == ALU_ILLEGAL) begin
                        resp_data_o <= '0;
                        resp_zero_o <= 1'b0;
                        resp_err_o  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    resp_data_o <= alu_data_i;
                    resp_zero_o <= alu_zero_i;
                    resp_err_o  <= 1'b0;
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        resp_data_o <= alu_data_i;
                        resp_zero_o <= alu_zero_i;
                        resp_err_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: if (resp_hs) last_grant <= id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the
// alu_* port; expected results are hand-computed constants.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req0_valid_i, req1_valid_i;
    logic             req0_ready_o, req1_ready_o;
    logic [WIDTH-1:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [2:0]       req0_ctrl_i, req1_ctrl_i;
    logic             resp0_valid_o, resp1_valid_o;
    logic             resp0_ready_i, resp1_ready_i;
    logic [WIDTH-1:0] resp_data_o;
    logic             resp_zero_o, resp_err_o;
    logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]       alu_ctrl_o;
    logic             alu_zero_i;
    logic             busy_o;

    int total = 0;
    int bad   = 0;
    logic saw_illegal_ctrl = 1'b0;

    always #5 clk_i = ~clk_i;

    alu_share_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(4), .FIXED_PRIO(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
        .resp_data_o(resp_data_o), .resp_zero_o(resp_zero_o), .resp_err_o(resp_err_o),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
        .busy_o(busy_o)
    );

    // External ALU
    always_comb begin
        alu_data_i = '0;
        case (alu_ctrl_o)
            3'b000: alu_data_i = alu_data1_o + alu_data2_o;
            3'b001: alu_data_i = $signed(alu_data1_o) >>> alu_data2_o[4:0];
            3'b010: alu_data_i = alu_data1_o - alu_data2_o;
            3'b011: alu_data_i = alu_data1_o * alu_data2_o;
            3'b100: alu_data_i = alu_data1_o ^ alu_data2_o;
            3'b101: alu_data_i = alu_data1_o & alu_data2_o;
            3'b111: alu_data_i = alu_data1_o << alu_data2_o[4:0];
            default: alu_data_i = '0;
        endcase
        alu_zero_i = (alu_data_i == '0);
    end

    always @(posedge clk_i) if (alu_ctrl_o === 3'b110) saw_illegal_ctrl = 1'b1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req0_valid_i = 0; req1_valid_i = 0;
        req0_data1_i = '0; req0_data2_i = '0; req0_ctrl_i = 3'b000;
        req1_data1_i = '0; req1_data2_i = '0; req1_ctrl_i = 3'b000;
        resp0_ready_i = 0; resp1_ready_i = 0;
        step(); step();
        rst_i = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_handshake: got %b want 0000", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o}); end
        total++; if ({resp_data_o, resp_zero_o, resp_err_o} !== '0) begin
            bad++; $display("FAIL reset_resp: got data=%0h zero=%b err=%b want 0", resp_data_o, resp_zero_o, resp_err_o); end
        total++; if ({alu_data1_o, alu_data2_o, alu_ctrl_o} !== '0) begin
            bad++; $display("FAIL reset_alu: got d1=%0h d2=%0h ctrl=%b want 0", alu_data1_o, alu_data2_o, alu_ctrl_o); end
    endtask

    task automatic test_add();
        step();
        resp0_ready_i = 1;
        req0_valid_i = 1; req0_data1_i = 5; req0_data2_i = 7; req0_ctrl_i = 3'b000;
        #1;
        total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", req0_ready_o); end
        step();
        req0_valid_i = 0; req0_data1_i = 100;
        #1;
        total++; if (alu_ctrl_o !== 3'b000 || alu_data1_o !== 5 || alu_data2_o !== 7) begin
            bad++; $display("FAIL add_alu_in: got ctrl=%b d1=%0d d2=%0d want 000/5/7", alu_ctrl_o, alu_data1_o, alu_data2_o); end
        total++; if (resp0_valid_o !== 1'b0) begin bad++; $display("FAIL add_early_valid: got %b want 0", resp0_valid_o); end
        step();
        total++; if (resp0_valid_o !== 1'b1 || resp1_valid_o !== 1'b0) begin
            bad++; $display("FAIL add_valid: got r0=%b r1=%b want 1/0", resp0_valid_o, resp1_valid_o); end
        total++; if (resp_data_o !== 12 || resp_zero_o !== 0 || resp_err_o !== 0) begin
            bad++; $display("FAIL add_data: got %0d z=%b e=%b want 12/0/0", resp_data_o, resp_zero_o, resp_err_o); end
        step();
        total++; if (busy_o !== 1'b0 || resp0_valid_o !== 1'b0) begin
            bad++; $display("FAIL add_idle: got busy=%b valid=%b want 0/0", busy_o, resp0_valid_o); end
    endtask

    task automatic test_tie();
        rst_i = 1; #1; rst_i = 0;
        step();
        resp0_ready_i = 1; resp1_ready_i = 1;
        req0_valid_i = 1; req0_data1_i = 9; req0_data2_i = 9; req0_ctrl_i = 3'b010;
        req1_valid_i = 1; req1_data1_i = 3; req1_data2_i = 5; req1_ctrl_i = 3'b100;
        #1;
        total++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
            bad++; $display("FAIL tie_first_grant: got r0=%b r1=%b want 1/0", req0_ready_o, req1_ready_o); end
        step();
        req0_valid_i = 0;
        #1;
        total++; if (req1_ready_o !== 1'b0) begin bad++; $display("FAIL tie_busy_ready: got %b want 0", req1_ready_o); end
        step();
        total++; if (resp0_valid_o !== 1'b1 || resp_data_o !== 0 || resp_zero_o !== 1'b1) begin
            bad++; $display("FAIL tie_sub: got v=%b data=%0d z=%b want 1/0/1", resp0_valid_o, resp_data_o, resp_zero_o); end
        step();
        total++; if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL tie_second_grant: got %b want 1", req1_ready_o); end
        step();
        req1_valid_i = 0;
        step();
        total++; if (resp1_valid_o !== 1'b1 || resp0_valid_o !== 1'b0 || resp_data_o !== 6 || resp_zero_o !== 1'b0) begin
            bad++; $display("FAIL tie_xor: got v1=%b v0=%b data=%0d z=%b want 1/0/6/0", resp1_valid_o, resp0_valid_o, resp_data_o, resp_zero_o); end
        step();
    endtask

    task automatic test_mul();
        resp1_ready_i = 1;
        req1_valid_i = 1; req1_data1_i = 6; req1_data2_i = 7; req1_ctrl_i = 3'b011;
        #1;
        total++; if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL mul_ready: got %b want 1", req1_ready_o); end
        for (int k = 1; k <= 4; k++) begin
            step();
            req1_valid_i = 0; req1_data1_i = 1;
            #1;
            total++; if (alu_ctrl_o !== 3'b011 || alu_data1_o !== 6 || alu_data2_o !== 7 || resp1_valid_o !== 1'b0) begin
                bad++; $display("FAIL mul_hold_%0d: got ctrl=%b d1=%0d d2=%0d v=%b want 011/6/7/0", k, alu_ctrl_o, alu_data1_o, alu_data2_o, resp1_valid_o); end
        end
        step();
        total++; if (resp1_valid_o !== 1'b1 || resp_data_o !== 42) begin
            bad++; $display("FAIL mul_result: got v=%b data=%0d want 1/42", resp1_valid_o, resp_data_o); end
        total++; if (alu_ctrl_o !== 3'b000 || alu_data1_o !== 0) begin
            bad++; $display("FAIL mul_resp_alu: got ctrl=%b d1=%0d want 000/0", alu_ctrl_o, alu_data1_o); end
        step();
    endtask

    task automatic test_illegal();
        resp0_ready_i = 1;
        req0_valid_i = 1; req0_data1_i = 3; req0_data2_i = 4; req0_ctrl_i = 3'b110;
        #1;
        total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL ill_ready: got %b want 1", req0_ready_o); end
        step();
        req0_valid_i = 0;
        #1;
        total++; if (resp0_valid_o !== 1'b1 || resp_data_o !== 0 || resp_err_o !== 1'b1 || resp_zero_o !== 1'b0) begin
            bad++; $display("FAIL ill_resp: got v=%b data=%0d e=%b z=%b want 1/0/1/0", resp0_valid_o, resp_data_o, resp_err_o, resp_zero_o); end
        step();
        total++; if (saw_illegal_ctrl !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL ill_alu_ctrl: got seen=%b busy=%b want 0/0", saw_illegal_ctrl, busy_o); end
    endtask

    task automatic test_back_pressure();
        resp0_ready_i = 0; resp1_ready_i = 1;
        req0_valid_i = 1; req0_data1_i = 1; req0_data2_i = 1; req0_ctrl_i = 3'b000;
        #1;
        total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready0: got %b want 1", req0_ready_o); end
        step();
        req0_valid_i = 0;
        req1_valid_i = 1; req1_data1_i = 2; req1_data2_i = 3; req1_ctrl_i = 3'b101;
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if (resp0_valid_o !== 1'b1 || resp_data_o !== 2 || req1_ready_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b data=%0d r1=%b want 1/2/0", k, resp0_valid_o, resp_data_o, req1_ready_o); end
            if (k < 3) step();
        end
        resp0_ready_i = 1;
        #1;
        total++; if (req1_ready_o !== 1'b0) begin bad++; $display("FAIL bp_overlap: got %b want 0", req1_ready_o); end
        step();
        total++; if (req1_ready_o !== 1'b1 || resp0_valid_o !== 1'b0) begin
            bad++; $display("FAIL bp_release: got r1=%b v0=%b want 1/0", req1_ready_o, resp0_valid_o); end
        step();
        req1_valid_i = 0;
        step();
        total++; if (resp1_valid_o !== 1'b1 || resp_data_o !== 2) begin
            bad++; $display("FAIL bp_and: got v=%b data=%0d want 1/2", resp1_valid_o, resp_data_o); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        resp0_ready_i = 1;
        req0_valid_i = 1; req0_data1_i = 3; req0_data2_i = 5; req0_ctrl_i = 3'b011;
        step();
        req0_valid_i = 0;
        step();
        total++; if (alu_ctrl_o !== 3'b011) begin bad++; $display("FAIL rst_mul_active: got %b want 011", alu_ctrl_o); end
        rst_i = 1;
        #1;
        total++; if (busy_o !== 0 || alu_ctrl_o !== 0 || alu_data1_o !== 0 || resp0_valid_o !== 0 || resp_data_o !== 0) begin
            bad++; $display("FAIL rst_mul_clear: got busy=%b ctrl=%b d1=%0d v=%b data=%0d want all 0", busy_o, alu_ctrl_o, alu_data1_o, resp0_valid_o, resp_data_o); end
        step();
        rst_i = 0;
        step(); step(); step(); step();
        total++; if (resp0_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL rst_mul_no_resp: got v=%b busy=%b want 0/0", resp0_valid_o, busy_o); end
        req0_valid_i = 1; req0_data1_i = 2; req0_data2_i = 3; req0_ctrl_i = 3'b000;
        #1;
        total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL rst_new_ready: got %b want 1", req0_ready_o); end
        step();
        req0_valid_i = 0;
        step();
        total++; if (resp0_valid_o !== 1'b1 || resp_data_o !== 5 || resp_err_o !== 1'b0) begin
            bad++; $display("FAIL rst_new_resp: got v=%b data=%0d e=%b want 1/5/0", resp0_valid_o, resp_data_o, resp_err_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_mul();
        test_illegal();
        test_back_pressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Two-requester scheduler that shares one combinational ALU instance (3-bit ALUCtrl: add/srai/sub/mul/xor/and/sll).
- Arbitrates requests with a valid/ready handshake, latches operands and drives the ALU from registers.
- Holds MUL operands stable for a multicycle window, then returns registered result/zero to the granted requester.
- Sits between the EX-stage issue logic and the shared ALU.

Parameters:
WIDTH, 32, operand/result width
MUL_CYCLES, 4, cycles ALU inputs are held for ctrl 3'b011 before capture; legal range 1..15
FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req0_valid_i  in  1  requester 0 has an op
req0_ready_o  out  1  requester 0 op accepted this cycle
req0_data1_i  in  WIDTH  operand 1
req0_data2_i  in  WIDTH  operand 2
req0_ctrl_i  in  3  ALU control code
req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i  as requester 0
resp0_valid_o  out  1  result for requester 0 available
resp0_ready_i  in  1  requester 0 consumes result
resp1_valid_o  out  1  result for requester 1 available
resp1_ready_i  in  1  requester 1 consumes result
resp_data_o  out  WIDTH  registered result, shared by both requesters
resp_zero_o  out  1  registered zero flag
resp_err_o  out  1  illegal ctrl code (3'b110)
alu_data1_o  out  WIDTH  to ALU data1
alu_data2_o  out  WIDTH  to ALU data2
alu_ctrl_o  out  3  to ALU control
alu_data_i  in  WIDTH  ALU result
alu_zero_i  in  1  ALU zero flag
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_i=1): state=IDLE; last_grant=1 (req0 wins first tie); all ready/valid outputs 0; resp_data_o=0, resp_zero_o=0, resp_err_o=0; alu_* outputs 0. Any in-flight op is discarded with no response.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - grant = valid requester; on a tie, the requester != last_grant (or req0 if FIXED_PRIO=1).
  - reqN_ready_o = IDLE && grant==N, combinational from valid.
  - On accept: latch data1/data2/ctrl and the grant id.
  - Next state: ctrl==3'b011 -> MUL with cnt=MUL_CYCLES-1; ctrl==3'b110 -> RESP with data=0, zero=0, err=1; otherwise -> EXEC.
- EXEC: alu_* driven from latched regs; at the clock edge, capture alu_data_i/alu_zero_i with err=0; -> RESP.
- MUL: alu_* held from latched regs. If cnt==0, capture and -> RESP; else cnt--. MUL_CYCLES=1 behaves like EXEC.
- RESP:
  - respN_valid_o=1 for the granted id only; resp_data/zero/err held stable.
  - When respN_ready_i=1: -> IDLE, last_grant=id.
  - Next accept is earliest the cycle after; no overlap.
- Latency, accept edge to resp_valid: 2 cycles for non-mul; 1+MUL_CYCLES for mul; 1 cycle for illegal.
- alu_ctrl_o/alu_data*_o = 0 in IDLE and RESP.
- Requesters must hold valid and operands until ready. Operand changes after accept are ignored.
- Valid with no ready while busy: no accept, no drop; the request simply waits.
- resp_ready_i while resp_valid=0: ignored.
- srai shift amount and sll/mul truncation are the ALU's concern; the arbiter passes WIDTH bits unchanged.

Decomposition:
- Shared package: ALU ctrl codes (ADD=000, SRAI=001, SUB=010, MUL=011, XOR=100, AND=101, ILLEGAL=110, SLL=111) and FSM state encoding.
- Sub-module rr_arb2: 2-way round-robin/fixed-priority grant from valid + last_grant.
- The ALU itself is external; the bench instantiates it.

Test Plan:
- req0 add 5+7, resp0_ready held 1 -> req0_ready at cycle 0; resp0_valid at cycle 2 with data=12, zero=0, err=0.
- Both valid from reset: req0 sub 9-9, req1 xor 3^5 -> req0 served first (data 0, zero=1); req1 accepted the cycle after resp0 handshake, data=6.
- req1 mul 6*7, MUL_CYCLES=4 -> alu_ctrl_o=011 stable 4 cycles; resp1_valid at cycle 5, data=42.
- req0 ctrl 110 -> resp0_valid at cycle 1, data=0, err=1; ALU never driven with 110.
- Backpressure: resp0_ready low 3 cycles after add 1+1 -> resp0_valid and data=2 held; req1 not accepted until release.
- Assert rst_i in the middle of MUL -> immediate IDLE, all outputs 0, no resp; a new request afterwards completes normally.
